// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_pkg                                                      |
// | Shared constants for the writeback stage: load-type codes and the    |
// | default datapath/address widths.                                     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_stage_if                                                 |
// | MEM-stage, mult/div and register-file-write signals of the writeback |
// | stage, with master (environment) and slave (stage) modports.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Flush;
  logic              MemValid;
  logic              MemRegWrite;
  logic [ADDR_W-1:0] MemRegWrAddr;
  logic              MemToReg;
  logic [DATA_W-1:0] MemAluResult;
  logic [DATA_W-1:0] MemRdData;
  logic [2:0]        MemLoadType;
  logic              LongValid;
  logic [ADDR_W-1:0] LongAddr;
  logic [DATA_W-1:0] LongData;
  logic              LongReady;
  logic              RegWrite;
  logic [ADDR_W-1:0] RegWrAddr;
  logic [DATA_W-1:0] RegWrData;

  modport master (
    output Flush, MemValid, MemRegWrite, MemRegWrAddr, MemToReg,
    output MemAluResult, MemRdData, MemLoadType,
    output LongValid, LongAddr, LongData,
    input  LongReady, RegWrite, RegWrAddr, RegWrData
  );

  modport slave (
    input  Flush, MemValid, MemRegWrite, MemRegWrAddr, MemToReg,
    input  MemAluResult, MemRdData, MemLoadType,
    input  LongValid, LongAddr, LongData,
    output LongReady, RegWrite, RegWrAddr, RegWrData
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : load_align                                                  |
// | Big-endian byte/halfword lane extraction with sign/zero extension.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_i,
  input  logic [2:0]        type_i,
  output logic [DATA_W-1:0] data_o
);

  logic [15:0] half_w;
  logic [7:0]  byte_w;

  always_comb begin
    half_w = addr_i[1] ? word_i[15:0] : word_i[31:16];
    case (addr_i)
      2'b00:   byte_w = word_i[31:24];
      2'b01:   byte_w = word_i[23:16];
      2'b10:   byte_w = word_i[15:8];
      default: byte_w = word_i[7:0];
    endcase

    // Unknown type codes fall through to a full-word load.
    case (type_i)
      LD_LH:   data_o = {{(DATA_W-16){half_w[15]}}, half_w};
      LD_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_w};
      LD_LB:   data_o = {{(DATA_W-8){byte_w[7]}}, byte_w};
      LD_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_w};
      default: data_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wb_stage                                                    |
// | Writeback stage: registers MEM results / load data and merges the    |
// | mult/div writer through a one-entry pending buffer.                  |
// | Option : WB_PEND_FWD_EN exposes the pending buffer for forwarding.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  wb_stage_if.slave         bus
`ifdef WB_PEND_FWD_EN
  ,
  output logic              PendValid,
  output logic [ADDR_W-1:0] PendAddr,
  output logic [DATA_W-1:0] PendData
`endif
);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_a_q, pend_a_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;

  logic              p_wr;
  logic              long_acc;
  logic              long_keep;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] mem_val;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .word_i (bus.MemRdData),
    .addr_i (bus.MemAluResult[1:0]),
    .type_i (bus.MemLoadType),
    .data_o (load_val)
  );

  assign p_wr      = bus.MemValid && bus.MemRegWrite && !bus.Flush &&
                     (bus.MemRegWrAddr != ADDR_W'(REG_ZERO));
  assign long_acc  = bus.LongValid && !pend_v_q;
  // r0 results complete the handshake but are never stored.
  assign long_keep = long_acc && (bus.LongAddr != ADDR_W'(REG_ZERO));
  assign mem_val   = bus.MemToReg ? load_val : bus.MemAluResult;

  always_comb begin
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_v_d    = pend_v_q;
    pend_a_d    = pend_a_q;
    pend_data_d = pend_data_q;

    if (p_wr) begin
      we_d   = 1'b1;
      addr_d = bus.MemRegWrAddr;
      data_d = mem_val;
      // Younger pipeline write supersedes an older buffered result.
      if (pend_v_q && (pend_a_q == bus.MemRegWrAddr)) begin
        pend_v_d = 1'b0;
      end
      if (long_keep) begin
        pend_v_d    = 1'b1;
        pend_a_d    = bus.LongAddr;
        pend_data_d = bus.LongData;
      end
    end else if (pend_v_q) begin
      we_d     = 1'b1;
      addr_d   = pend_a_q;
      data_d   = pend_data_q;
      pend_v_d = 1'b0;
      if (long_keep) begin
        pend_v_d    = 1'b1;
        pend_a_d    = bus.LongAddr;
        pend_data_d = bus.LongData;
      end
    end else if (long_keep) begin
      we_d   = 1'b1;
      addr_d = bus.LongAddr;
      data_d = bus.LongData;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_a_q    <= '0;
      pend_data_q <= '0;
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_v_q    <= pend_v_d;
      pend_a_q    <= pend_a_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign bus.LongReady = !pend_v_q;
  assign bus.RegWrite  = we_q;
  assign bus.RegWrAddr = addr_q;
  assign bus.RegWrData = data_q;

`ifdef WB_PEND_FWD_EN
  assign PendValid = pend_v_q;
  assign PendAddr  = pend_a_q;
  assign PendData  = pend_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_wb_stage                                                 |
// | Self-checking bench: directed scenarios plus randomized traffic      |
// | against a behavioural writeback model.                               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_wb_stage;

  logic Clk;
  logic Rst_n;
  int   errors;
  int   checks;

  wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef WB_PEND_FWD_EN
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic [31:0] pend_data;
`endif

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
`ifdef WB_PEND_FWD_EN
    ,
    .PendValid (pend_valid),
    .PendAddr  (pend_addr),
    .PendData  (pend_data)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference state: what the register-file port should show, plus the buffered long result.
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_pv;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] a, logic [2:0] t);
    logic [31:0] v;
    int lane;
    case (t)
      3'b001, 3'b010: begin
        v = (w >> (a[1] ? 0 : 16)) & 32'h0000FFFF;
        if (t == 3'b001 && v[15]) v = v | 32'hFFFF0000;
      end
      3'b011, 3'b100: begin
        lane = 3 - int'(a);
        v = (w >> (8 * lane)) & 32'h000000FF;
        if (t == 3'b011 && v[7]) v = v | 32'hFFFFFF00;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_we = 0; m_addr = 0; m_data = 0; m_pv = 0; m_pa = 0; m_pd = 0;
  endtask

  task automatic idle_inputs();
    bus.Flush = 0; bus.MemValid = 0; bus.MemRegWrite = 0; bus.MemRegWrAddr = 0;
    bus.MemToReg = 0; bus.MemAluResult = 0; bus.MemRdData = 0; bus.MemLoadType = 0;
    bus.LongValid = 0; bus.LongAddr = 0; bus.LongData = 0;
  endtask

  task automatic mem_drive(input logic [4:0] a, input logic to_reg, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [2:0] lt);
    bus.MemValid = 1; bus.MemRegWrite = 1; bus.MemRegWrAddr = a; bus.MemToReg = to_reg;
    bus.MemAluResult = alu; bus.MemRdData = rd; bus.MemLoadType = lt;
  endtask

  task automatic long_drive(input logic [4:0] a, input logic [31:0] d);
    bus.LongValid = 1; bus.LongAddr = a; bus.LongData = d;
  endtask

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic cycle();
    logic        pw, ready, keep, hit;
    logic        n_we, n_pv;
    logic [4:0]  n_addr, n_pa;
    logic [31:0] n_data, n_pd;
    pw    = bus.MemValid && bus.MemRegWrite && !bus.Flush && (bus.MemRegWrAddr != 0);
    ready = !m_pv;
    keep  = bus.LongValid && ready && (bus.LongAddr != 0);
    hit   = m_pv && pw && (m_pa == bus.MemRegWrAddr);
    n_we = 0; n_addr = m_addr; n_data = m_data;
    n_pv = m_pv && !hit; n_pa = m_pa; n_pd = m_pd;
    if (pw) begin
      n_we = 1; n_addr = bus.MemRegWrAddr;
      n_data = bus.MemToReg ? ref_load(bus.MemRdData, bus.MemAluResult[1:0], bus.MemLoadType)
                            : bus.MemAluResult;
      if (keep) begin n_pv = 1; n_pa = bus.LongAddr; n_pd = bus.LongData; end
    end else if (m_pv) begin
      n_we = 1; n_addr = m_pa; n_data = m_pd; n_pv = 0;
    end else if (keep) begin
      n_we = 1; n_addr = bus.LongAddr; n_data = bus.LongData;
    end
    @(posedge Clk);
    #1;
    m_we = n_we; m_addr = n_addr; m_data = n_data; m_pv = n_pv; m_pa = n_pa; m_pd = n_pd;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    Rst_n = 0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.RegWrite); end
    checks++; if (bus.RegWrAddr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.RegWrAddr); end
    checks++; if (bus.RegWrData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.RegWrData); end
    checks++; if (bus.LongReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.LongReady); end
    Rst_n = 1;
    cycle();
  endtask

  task automatic test_loads();
    logic [2:0]  lt  [6] = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b000, 3'b111};
    logic [31:0] rd  [6] = '{32'h8899AABB, 32'h8899AABB, 32'h1234F00D, 32'h1234F00D, 32'h1234F00D, 32'hCAFEF00D};
    logic [31:0] ad  [6] = '{32'h1001, 32'h1001, 32'h2002, 32'h2003, 32'h3003, 32'h0002};
    logic [31:0] exp [6] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFF00D, 32'h0000F00D, 32'h1234F00D, 32'hCAFEF00D};
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      mem_drive(5'd5, 1'b1, ad[i], rd[i], lt[i]);
      cycle();
      checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL load%0d_we: got %b expected 1", i, bus.RegWrite); end
      checks++; if (bus.RegWrAddr !== 5'd5) begin errors++; $display("FAIL load%0d_addr: got %0d expected 5", i, bus.RegWrAddr); end
      checks++; if (bus.RegWrData !== exp[i]) begin errors++; $display("FAIL load%0d_data: got %h expected %h", i, bus.RegWrData, exp[i]); end
    end
    idle_inputs();
    mem_drive(5'd31, 1'b0, 32'hDEADBEEF, 32'h0, 3'b011);
    cycle();
    checks++; if (bus.RegWrAddr !== 5'd31) begin errors++; $display("FAIL alu_addr: got %0d expected 31", bus.RegWrAddr); end
    checks++; if (bus.RegWrData !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data: got %h expected deadbeef", bus.RegWrData); end
  endtask

  task automatic test_suppress();
    idle_inputs();
    mem_drive(5'd0, 1'b0, 32'h12345678, 32'h0, 3'b000);
    cycle();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL r0_we: got %b expected 0", bus.RegWrite); end
    checks++; if (bus.RegWrAddr !== 5'd31) begin errors++; $display("FAIL hold_addr: got %0d expected 31", bus.RegWrAddr); end
    idle_inputs();
    mem_drive(5'd7, 1'b0, 32'h77777777, 32'h0, 3'b000);
    bus.Flush = 1;
    cycle();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL flush_we: got %b expected 0", bus.RegWrite); end
    checks++; if (bus.RegWrData !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_data: got %h expected deadbeef", bus.RegWrData); end
    idle_inputs();
    long_drive(5'd0, 32'h55555555);
    cycle();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL long_r0_we: got %b expected 0", bus.RegWrite); end
    checks++; if (bus.LongReady !== 1'b1) begin errors++; $display("FAIL long_r0_ready: got %b expected 1", bus.LongReady); end
  endtask

  task automatic test_collision();
    idle_inputs();
    long_drive(5'd9, 32'h000000AA);
    cycle();
    checks++; if (bus.RegWrite !== 1'b1 || bus.RegWrAddr !== 5'd9 || bus.RegWrData !== 32'hAA) begin
      errors++; $display("FAIL long_direct: got we=%b a=%0d d=%h expected we=1 a=9 d=aa", bus.RegWrite, bus.RegWrAddr, bus.RegWrData); end
    idle_inputs();
    mem_drive(5'd3, 1'b0, 32'd1, 32'h0, 3'b000);
    long_drive(5'd4, 32'd2);
    cycle();
    checks++; if (bus.RegWrite !== 1'b1 || bus.RegWrAddr !== 5'd3 || bus.RegWrData !== 32'd1) begin
      errors++; $display("FAIL coll_mem: got we=%b a=%0d d=%h expected we=1 a=3 d=1", bus.RegWrite, bus.RegWrAddr, bus.RegWrData); end
    checks++; if (bus.LongReady !== 1'b0) begin errors++; $display("FAIL coll_busy: got %b expected 0", bus.LongReady); end
    idle_inputs();
    cycle();
    checks++; if (bus.RegWrite !== 1'b1 || bus.RegWrAddr !== 5'd4 || bus.RegWrData !== 32'd2) begin
      errors++; $display("FAIL coll_pend: got we=%b a=%0d d=%h expected we=1 a=4 d=2", bus.RegWrite, bus.RegWrAddr, bus.RegWrData); end
    checks++; if (bus.LongReady !== 1'b1) begin errors++; $display("FAIL coll_ready: got %b expected 1", bus.LongReady); end
    cycle();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL one_pulse: got %b expected 0", bus.RegWrite); end
  endtask

  task automatic test_waw();
    idle_inputs();
    mem_drive(5'd3, 1'b0, 32'd1, 32'h0, 3'b000);
    long_drive(5'd4, 32'd5);
    cycle();
    idle_inputs();
    mem_drive(5'd4, 1'b0, 32'd9, 32'h0, 3'b000);
    cycle();
    checks++; if (bus.RegWrite !== 1'b1 || bus.RegWrAddr !== 5'd4 || bus.RegWrData !== 32'd9) begin
      errors++; $display("FAIL waw_write: got we=%b a=%0d d=%h expected we=1 a=4 d=9", bus.RegWrite, bus.RegWrAddr, bus.RegWrData); end
    checks++; if (bus.LongReady !== 1'b1) begin errors++; $display("FAIL waw_ready: got %b expected 1", bus.LongReady); end
    idle_inputs();
    cycle();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL waw_drop: got %b expected 0", bus.RegWrite); end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    mem_drive(5'd3, 1'b0, 32'd1, 32'h0, 3'b000);
    long_drive(5'd4, 32'd2);
    cycle();
    idle_inputs();
    #2;
    Rst_n = 0;
    #1;
    model_reset();
    checks++; if (bus.RegWrite !== 1'b0 || bus.RegWrAddr !== 5'd0 || bus.RegWrData !== 32'h0) begin
      errors++; $display("FAIL arst_out: got we=%b a=%0d d=%h expected all 0", bus.RegWrite, bus.RegWrAddr, bus.RegWrData); end
    @(negedge Clk);
    Rst_n = 1;
    cycle();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL arst_lost: got %b expected 0", bus.RegWrite); end
    checks++; if (bus.LongReady !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", bus.LongReady); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      bus.MemValid     = ($urandom_range(0, 3) != 0);
      bus.MemRegWrite  = ($urandom_range(0, 4) != 0);
      bus.Flush        = ($urandom_range(0, 7) == 0);
      bus.MemRegWrAddr = 5'($urandom_range(0, 6));
      bus.MemToReg     = 1'($urandom);
      bus.MemAluResult = $urandom;
      bus.MemRdData    = $urandom;
      bus.MemLoadType  = 3'($urandom_range(0, 7));
      bus.LongValid    = ($urandom_range(0, 2) == 0);
      bus.LongAddr     = 5'($urandom_range(0, 6));
      bus.LongData     = $urandom;
      cycle();
      checks++; if (bus.RegWrite !== m_we) begin errors++; $display("FAIL rnd%0d_we: got %b expected %b", i, bus.RegWrite, m_we); end
      checks++; if (bus.RegWrAddr !== m_addr) begin errors++; $display("FAIL rnd%0d_addr: got %0d expected %0d", i, bus.RegWrAddr, m_addr); end
      checks++; if (bus.RegWrData !== m_data) begin errors++; $display("FAIL rnd%0d_data: got %h expected %h", i, bus.RegWrData, m_data); end
      checks++; if (bus.LongReady !== !m_pv) begin errors++; $display("FAIL rnd%0d_ready: got %b expected %b", i, bus.LongReady, !m_pv); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Rst_n  = 1;
    test_reset();
    test_loads();
    test_suppress();
    test_collision();
    test_waw();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage that directly feeds the 32x32 register file's write port (RegWrAddr/RegWrData/RegWrite).
- Registers the MEM-stage result and performs load byte/halfword extraction with sign or zero extension.
- Arbitrates a second writer, the multi-cycle mult/div unit, through a one-entry pending buffer with backpressure.
- Outputs update on posedge Clk; the register file writes on the following negedge, so data is stable half a cycle before the write.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Flush  in  1  squash the MEM entry captured this cycle
MemValid  in  1  MEM stage presents an instruction
MemRegWrite  in  1  instruction writes a register
MemRegWrAddr  in  ADDR_W  destination register
MemToReg  in  1  1 = load data, 0 = ALU result
MemAluResult  in  DATA_W  ALU result / load address
MemRdData  in  DATA_W  raw data-memory word
MemLoadType  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
LongValid  in  1  mult/div result available
LongAddr  in  ADDR_W  mult/div destination
LongData  in  DATA_W  mult/div result
LongReady  out  1  mult/div result accepted when LongValid && LongReady
RegWrite  out  1  register file write enable
RegWrAddr  out  ADDR_W  register file write address
RegWrData  out  DATA_W  register file write data

Behaviour:
- Reset (Rst_n low, async): RegWrite=0, RegWrAddr=0, RegWrData=0, pending buffer empty. LongReady is combinational and reads 1 once the pending buffer is empty.
- MEM path is always accepted (no MemReady). Latency from MEM inputs to outputs is 1 cycle.
- p_wr = MemValid && MemRegWrite && !Flush && (MemRegWrAddr != 0).
- Data select: MemToReg=0 gives MemAluResult. MemToReg=1 gives the extracted load value.
- Load extraction is big-endian; lane is taken from MemAluResult[1:0]:
  - LW: the full word; the low address bits are ignored.
  - LH/LHU: addr[1]=0 selects [31:16], addr[1]=1 selects [15:0]. addr[0] is ignored (no misaligned trap here).
  - LB/LBU: addr 00 selects [31:24], 01 selects [23:16], 10 selects [15:8], 11 selects [7:0].
  - LH/LB sign-extend; LHU/LBU zero-extend.
  - Undefined MemLoadType codes are treated as LW.
- LongReady = !pend_valid.
- Each posedge, in priority order:
  1. If p_wr, the output register takes the MEM write. An accepted long result goes into the pending buffer. An already-pending entry stays pending.
  2. Otherwise, if pend_valid, the output takes the pending entry and the buffer clears. An accepted long result in the same cycle refills the buffer.
  3. Otherwise, if LongValid (LongReady=1 here), the output takes the long result directly; 1-cycle latency, bypassing the buffer.
  4. Otherwise RegWrite=0. RegWrAddr/RegWrData hold their last values.
- Long writes to address 0 are accepted (handshake completes) but dropped: never buffered, never written.
- WAW rule: if p_wr targets the same address as a valid pending entry, the pending entry is discarded that cycle. The younger pipeline write wins.
- Pending entries can starve only while p_wr is continuously high. No fairness counter is required.
- Flush affects only the MEM entry of that cycle. Pending and long results are never flushed.
- RegWrite is high for exactly one cycle per write.
- Reset asserted mid-operation drops the pending entry and any in-flight write.

Optional Feature:
- Macro: WB_PEND_FWD_EN.
- Defined: adds outputs PendValid (1), PendAddr (ADDR_W), PendData (DATA_W), which mirror the pending buffer. The ID-stage bypass mux uses them to forward a buffered mult/div result.
- Undefined: these ports are absent. The hazard unit must stall any read of a register whose result is pending (LongReady=0 signals this).

Decomposition:
- wb_pkg holds:
  - LD_LW/LD_LH/LD_LHU/LD_LB/LD_LBU 3-bit constants
  - DATA_W/ADDR_W defaults
  - REG_ZERO constant
- Sub-module load_align: purely combinational. Inputs are raw word, addr[1:0] and load type; output is the extended value. It is instantiated once in wb_stage.

Test Plan:
- LB, MemRdData=32'h8899AABB, addr[1:0]=2'b01, dest r5 -> next cycle RegWrite=1, RegWrAddr=5, RegWrData=32'hFFFFFF99. Same with LBU -> 32'h00000099.
- LH addr[1]=1 on 32'h1234F00D -> 32'hFFFFF00D. LHU -> 32'h0000F00D. ALU path with MemToReg=0, value 32'hDEADBEEF, dest r31 -> 32'hDEADBEEF.
- MEM write to r0, and Flush with a valid write to r7 -> RegWrite stays 0 for both cycles.
- Collision: p_wr r3 <- 1 and LongValid r4 <- 2 in cycle N.
  - Cycle N+1: writes r3, LongReady=0.
  - Cycle N+2 (no p_wr): writes r4 <- 2, LongReady=1.
- WAW: pending r4 plus p_wr to r4 <- 9 -> only r4 <- 9 is written; the pending entry is discarded and LongReady returns to 1.
- Assert Rst_n=0 with a pending entry mid-cycle -> outputs go to 0 immediately, the pending entry is lost, and LongReady=1 after release.
